pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges the load-use hazard, the ID-stage branch redirect and a variable-latency data-memory handshake into per-register control for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also raises a sticky error on memory timeout. Internally it is an FSM plus a wait counter; the datapath registers only receive its stall, flush and bubble controls.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive wait cycles for mem_ack_i; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  level; sampled in IDLE to begin execution.
- loaduse_i  in  1  load-use hazard; the instruction in ID depends on a load in EX.
- branch_taken_i  in  1  branch resolved taken in ID.
- mem_access_i  in  1  EX/MEM holds a load or store.
- mem_ack_i  in  1  data memory completes the access this cycle.
- mem_req_o  out  1  memory request.
- pc_write_o  out  1  PC update enable.
- ifid_stall_o  out  1  hold IF/ID.
- ifid_flush_o  out  1  zero IF/ID.
- idex_bubble_o  out  1  load zeros into ID/EX.
- idex_stall_o  out  1  hold ID/EX.
- exmem_stall_o  out  1  hold EX/MEM.
- memwb_bubble_o  out  1  load zeros into MEM/WB.
- err_o  out  1  sticky memory timeout.
- stall_cnt_o  out  CNT_W  stall cycle count.
- flush_cnt_o  out  CNT_W  flush count.

## Operation
- FSM states: IDLE, RUN, MEM_WAIT, ERROR. Outputs are Mealy: they are derived from the state and the current inputs.
- IDLE:
  - Outputs: pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1, all other controls 0.
  - Transition: start_i=1 moves to RUN at the next edge.
- RUN:
  - mem_req_o = mem_access_i.
  - freeze = mem_access_i & ~mem_ack_i.
  - Priority 1, freeze: pc_write_o=0, ifid_stall_o=1, idex_stall_o=1, exmem_stall_o=1, memwb_bubble_o=1. Next state is MEM_WAIT and the wait counter clears.
  - Priority 2, loaduse_i: pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1. branch_taken_i is ignored this cycle.
  - Priority 3, branch_taken_i: pc_write_o=1, ifid_flush_o=1.
  - Otherwise: pc_write_o=1 and all other controls 0.
- MEM_WAIT:
  - mem_req_o=1.
  - Without mem_ack_i: the full freeze holds and the wait counter increments. If the counter reaches MEM_TIMEOUT-1 (MEM_TIMEOUT≠0), the next state is ERROR.
  - With mem_ack_i: the freeze drops this cycle, so MEM/WB captures the data and the pipeline advances. The loaduse_i and branch_taken_i priorities apply as in RUN, and the next state is RUN.
- ERROR: full freeze, mem_req_o=0, err_o=1. Only rst_i exits this state.
- If mem_ack_i arrives with no outstanding request, it is ignored.
- The idex stall and bubble are never asserted together.
- The wait counter width is $clog2(MEM_TIMEOUT+1) with a minimum of 1, and it never wraps.

## Timing
- Reset value of every output:
  - State is IDLE.
  - pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1.
  - ifid_flush_o, idex_stall_o, exmem_stall_o, memwb_bubble_o, mem_req_o and err_o are 0.
  - Both counters are 0.
- Reset during MEM_WAIT or ERROR returns the FSM to IDLE immediately (asynchronous), and the request drops.
- A zero-latency memory (ack in the same cycle as the access) causes no stall cycles.
- A memory acked N cycles after the access costs exactly N freeze cycles.
- A load-use hazard costs exactly one bubble cycle per assertion.
- A taken branch costs one flushed slot.

## Configuration
- PIPE_CTRL_PERF_CNT_EN
  - Defined: stall_cnt_o increments on every cycle in RUN or MEM_WAIT with pc_write_o=0. flush_cnt_o increments on every cycle with ifid_flush_o=1. Both counters saturate at all-ones and clear on reset.
  - Undefined: the counters are not built and both ports are tied to 0.

## Test plan
- Reset, then hold start_i=0 for 5 cycles: pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1 throughout. Set start_i=1: pc_write_o=1 one cycle later.
- In RUN, pulse loaduse_i=1 and branch_taken_i=1 together for 1 cycle: exactly one cycle of pc_write_o=0 with idex_bubble_o=1, ifid_flush_o=0. Then branch_taken_i alone: ifid_flush_o=1, flush_cnt_o=1.
- Set mem_access_i=1 and ack 3 cycles later: freeze asserted for 3 cycles, released in the ack cycle, stall_cnt_o=3 (when PERF_CNT_EN is defined).
- Set mem_access_i=1 with ack in the same cycle: no freeze, and the state stays RUN.
- With MEM_TIMEOUT=4, hold mem_access_i=1 and never ack: err_o=1 after the 5th freeze cycle. A later mem_ack_i has no effect; rst_i clears err_o.
- Assert rst_i in the middle of MEM_WAIT: all outputs return to their reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RISC-V pipeline.
// Merges the load-use hazard, ID-stage branch redirect and data-memory
// handshake into per-register controls. All controls are Mealy outputs,
// so an asynchronous reset takes them to their idle values at once.
// Optional build macro: PIPE_CTRL_PERF_CNT_EN adds saturating stall/flush
// counters; without it both counter ports read 0.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             loaduse_i,
  input  logic             branch_taken_i,
  input  logic             mem_access_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             idex_stall_o,
  output logic             exmem_stall_o,
  output logic             memwb_bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST =
    WCNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic              wcnt_clr, wcnt_inc;

  // State register; reset lands in IDLE asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Consecutive memory wait cycles; saturates instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                             wcnt <= '0;
    else if (wcnt_clr)                     wcnt <= '0;
    else if (wcnt_inc && wcnt != WCNT_MAX) wcnt <= wcnt + 1'b1;
  end

  // Next state and Mealy controls. Freeze has top priority, then load-use
  // (which swallows a same-cycle branch), then the branch redirect.
  always_comb begin
    state_nxt      = state;
    wcnt_clr       = 1'b0;
    wcnt_inc       = 1'b0;
    mem_req_o      = 1'b0;
    pc_write_o     = 1'b0;
    ifid_stall_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    idex_stall_o   = 1'b0;
    exmem_stall_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    err_o          = 1'b0;
    case (state)
      S_IDLE: begin
        ifid_stall_o  = 1'b1;
        idex_bubble_o = 1'b1;
        if (start_i) state_nxt = S_RUN;
      end
      S_RUN, S_MEM_WAIT: begin
        mem_req_o = (state == S_MEM_WAIT) ? 1'b1 : mem_access_i;
        if ((state == S_MEM_WAIT || mem_access_i) && !mem_ack_i) begin
          ifid_stall_o   = 1'b1;
          idex_stall_o   = 1'b1;
          exmem_stall_o  = 1'b1;
          memwb_bubble_o = 1'b1;
          if (state == S_RUN) begin
            state_nxt = S_MEM_WAIT;
            wcnt_clr  = 1'b1;
          end else begin
            wcnt_inc = 1'b1;
            if (MEM_TIMEOUT != 0 && wcnt == WCNT_LAST) state_nxt = S_ERROR;
          end
        end else begin
          // Memory done (or idle): pipeline advances subject to ID hazards.
          state_nxt = S_RUN;
          if (loaduse_i) begin
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
          end else if (branch_taken_i) begin
            pc_write_o   = 1'b1;
            ifid_flush_o = 1'b1;
          end else begin
            pc_write_o = 1'b1;
          end
        end
      end
      default: begin
        ifid_stall_o   = 1'b1;
        idex_stall_o   = 1'b1;
        exmem_stall_o  = 1'b1;
        memwb_bubble_o = 1'b1;
        err_o          = 1'b1;
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             stall_hit;

  assign stall_hit = (state == S_RUN || state == S_MEM_WAIT) && !pc_write_o;

  // Saturating performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_hit && stall_cnt != '1)    stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush_o && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MEM_TIMEOUT=4). Each step drives
// inputs, queues the expected control vector, then pops and checks it
// mid-cycle. Vector order: {req,pcw,ifid_stall,ifid_flush,idex_bubble,
// idex_stall,exmem_stall,memwb_bubble,err}.
module tb_pipeline_ctrl;
  localparam int CNT_W = 32;

  logic clk, rst, start, loaduse, branch, access, ack;
  logic mem_req, pc_write, ifid_stall, ifid_flush, idex_bubble;
  logic idex_stall, exmem_stall, memwb_bubble, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string      tag;
    logic [8:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [8:0] V_IDLE   = 9'b0_0_1_0_1_0_0_0_0;
  localparam logic [8:0] V_RUN    = 9'b0_1_0_0_0_0_0_0_0;
  localparam logic [8:0] V_RUNACK = 9'b1_1_0_0_0_0_0_0_0;
  localparam logic [8:0] V_FRZ    = 9'b1_0_1_0_0_1_1_1_0;
  localparam logic [8:0] V_LU     = 9'b0_0_1_0_1_0_0_0_0;
  localparam logic [8:0] V_LUACK  = 9'b1_0_1_0_1_0_0_0_0;
  localparam logic [8:0] V_BR     = 9'b0_1_0_1_0_0_0_0_0;
  localparam logic [8:0] V_ERR    = 9'b0_0_1_0_0_1_1_1_1;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .loaduse_i(loaduse),
    .branch_taken_i(branch), .mem_access_i(access), .mem_ack_i(ack),
    .mem_req_o(mem_req), .pc_write_o(pc_write), .ifid_stall_o(ifid_stall),
    .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble),
    .idex_stall_o(idex_stall), .exmem_stall_o(exmem_stall),
    .memwb_bubble_o(memwb_bubble), .err_o(err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {mem_req, pc_write, ifid_stall, ifid_flush, idex_bubble,
            idex_stall, exmem_stall, memwb_bubble, err};
  endfunction

  // Pop the oldest expectation and compare against the live outputs.
  task automatic check_out();
    exp_t e;
    logic [8:0] o;
    e = exp_q.pop_front();
    o = obs();
    n_tests++;
    assert (o === e.vec) else begin
      n_fail++;
      $error("FAIL %s: got %b want %b", e.tag, o, e.vec);
    end
  endtask

  task automatic check_cnt(input string tag, input int s_exp, input int f_exp);
    int s, f;
`ifdef PIPE_CTRL_PERF_CNT_EN
    s = s_exp; f = f_exp;
`else
    s = 0; f = 0;
`endif
    n_tests++;
    assert (stall_cnt === CNT_W'(s) && flush_cnt === CNT_W'(f)) else begin
      n_fail++;
      $error("FAIL %s: got stall=%0d flush=%0d want stall=%0d flush=%0d",
             tag, stall_cnt, flush_cnt, s, f);
    end
  endtask

  // One clock: drive inputs 1 after the edge, check 3 later, wait next edge.
  task automatic step(input logic s, input logic lu, input logic br,
                      input logic ac, input logic ak,
                      input string tag, input logic [8:0] v);
    exp_t e;
    start = s; loaduse = lu; branch = br; access = ac; ack = ak;
    e.tag = tag; e.vec = v;
    exp_q.push_back(e);
    #3;
    check_out();
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; start = 0; loaduse = 0; branch = 0; access = 0; ack = 0;
    #2;
    e.tag = "reset"; e.vec = V_IDLE; exp_q.push_back(e);
    check_out();
    check_cnt("reset_cnt", 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, "idle_hold", V_IDLE);
    step(1, 0, 0, 0, 0, "idle_start", V_IDLE);
    step(0, 0, 0, 0, 0, "run_enter", V_RUN);

    // Load-use wins over a same-cycle branch, costs one bubble.
    step(0, 1, 1, 0, 0, "lu_and_br", V_LU);
    step(0, 0, 0, 0, 0, "after_lu", V_RUN);
    step(0, 0, 1, 0, 0, "branch", V_BR);
    step(0, 0, 0, 0, 0, "after_br", V_RUN);
    check_cnt("cnt_br", 1, 1);

    // Ack three cycles after the access: three freeze cycles.
    step(0, 0, 0, 1, 0, "mem3_f0", V_FRZ);
    step(0, 0, 0, 1, 0, "mem3_f1", V_FRZ);
    step(0, 0, 0, 1, 0, "mem3_f2", V_FRZ);
    step(0, 0, 0, 1, 1, "mem3_ack", V_RUNACK);
    step(0, 0, 0, 0, 0, "mem3_done", V_RUN);
    check_cnt("cnt_mem3", 4, 1);

    // Same-cycle ack: no freeze, stays in RUN (no lingering request).
    step(0, 0, 0, 1, 1, "mem0_ack", V_RUNACK);
    step(0, 0, 0, 0, 0, "mem0_run", V_RUN);
    // Stray ack without request is ignored.
    step(0, 0, 0, 0, 1, "stray_ack", V_RUN);
    check_cnt("cnt_mem0", 4, 1);

    // Ack in MEM_WAIT together with load-use: bubble on release.
    step(0, 0, 0, 1, 0, "wlu_f0", V_FRZ);
    step(0, 1, 1, 1, 1, "wlu_ack", V_LUACK);
    step(0, 0, 0, 0, 0, "wlu_run", V_RUN);
    check_cnt("cnt_wlu", 6, 1);

    // Timeout: five freeze cycles, then ERROR; later ack changes nothing.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, "to_freeze", V_FRZ);
    step(0, 0, 0, 1, 0, "to_error", V_ERR);
    step(0, 0, 0, 1, 1, "err_ack", V_ERR);
    step(1, 0, 0, 0, 0, "err_sticky", V_ERR);
    check_cnt("cnt_err", 11, 1);

    // Asynchronous reset from ERROR, checked before any clock edge.
    rst = 1'b1; #1;
    e.tag = "rst_err"; e.vec = V_IDLE; exp_q.push_back(e);
    check_out();
    check_cnt("rst_err_cnt", 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    step(1, 0, 0, 0, 0, "restart", V_IDLE);
    step(0, 0, 0, 0, 0, "rerun", V_RUN);
    step(0, 0, 0, 1, 0, "mw_f0", V_FRZ);
    // Now in MEM_WAIT: assert reset mid-cycle.
    start = 0; loaduse = 0; branch = 0; access = 1; ack = 0;
    #3;
    e.tag = "mw_f1"; e.vec = V_FRZ; exp_q.push_back(e);
    check_out();
    rst = 1'b1; #1;
    e.tag = "rst_memwait"; e.vec = V_IDLE; exp_q.push_back(e);
    check_out();
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 0, 0, 1, 0, "post_rst_idle", V_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
